fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation MIPS32 core, replacing the single-cycle PC register and direct ROM read. Owns the program counter, issues pipelined requests to instruction memory, buffers returned instructions in a DEPTH-entry prefetch queue, and hands them to decode with a valid/ready handshake. Handles redirects, exceptions and interrupts, including discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 94 +++++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and flush-cause type for the fetch front end
// Contents:
//   XLEN_DEFAULT      default PC/data width
//   RESET_PC_DEFAULT  default first fetch address
//   IRQ_VEC_DEFAULT   default interrupt vector
//   EXC_VEC_DEFAULT   default exception vector
//   flush_cause_e     winning flush cause for the current cycle
package fetch_pkg;

   localparam int          XLEN_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] IRQ_VEC_DEFAULT  = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h8000_0008;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'd0,
      CAUSE_EXC   = 2'd1,
      CAUSE_REDIR = 2'd2,
      CAUSE_IRQ   = 2'd3
   } flush_cause_e;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch circular buffer with alloc/fill/pop/flush
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   flush                empty the buffer (wins over alloc/fill/pop)
//   alloc, alloc_pc      reserve the next slot for a request to alloc_pc
//   fill, fill_data      write a returned word into the oldest unfilled slot
//   pop                  retire the head slot
//   head_filled          head slot holds an instruction
//   head_pc, head_instr  head slot contents
//   empty                no slots allocated
//   occupancy            slots filled but not yet popped
//   in_flight            slots allocated but not yet filled
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   alloc,
   input  logic [XLEN-1:0]        alloc_pc,
   input  logic                   fill,
   input  logic [31:0]            fill_data,
   input  logic                   pop,
   output logic                   head_filled,
   output logic [XLEN-1:0]        head_pc,
   output logic [31:0]            head_instr,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [$clog2(DEPTH):0] in_flight
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      head_ptr;
   logic [AW:0]      fill_ptr;
   logic [AW:0]      alloc_ptr;
   logic [XLEN-1:0]  pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];
   logic [DEPTH-1:0] filled;
   logic             fill_ok;
   logic             pop_ok;

   // A response can only land in a slot that was actually requested.
   assign fill_ok = fill && (fill_ptr != alloc_ptr);
   assign pop_ok  = pop && head_filled;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_ptr  <= '0;
         fill_ptr  <= '0;
         alloc_ptr <= '0;
         filled    <= '0;
      end else if (flush) begin
         head_ptr  <= '0;
         fill_ptr  <= '0;
         alloc_ptr <= '0;
         filled    <= '0;
      end else begin
         if (alloc) begin
            alloc_ptr <= alloc_ptr + (AW+1)'(1);
         end
         if (fill_ok) begin
            filled[fill_ptr[AW-1:0]] <= 1'b1;
            fill_ptr                 <= fill_ptr + (AW+1)'(1);
         end
         if (pop_ok) begin
            filled[head_ptr[AW-1:0]] <= 1'b0;
            head_ptr                 <= head_ptr + (AW+1)'(1);
         end
      end
   end

   // Payload storage needs no reset; the filled flags qualify it.
   always_ff @(posedge clk) begin
      if (alloc && !flush) begin
         pc_mem[alloc_ptr[AW-1:0]] <= alloc_pc;
      end
      if (fill_ok && !flush) begin
         instr_mem[fill_ptr[AW-1:0]] <= fill_data;
      end
   end

   assign head_filled = filled[head_ptr[AW-1:0]];
   assign head_pc     = pc_mem[head_ptr[AW-1:0]];
   assign head_instr  = instr_mem[head_ptr[AW-1:0]];
   assign empty       = (alloc_ptr == head_ptr);
   assign occupancy   = fill_ptr - head_ptr;
   assign in_flight   = alloc_ptr - fill_ptr;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end: PC, request issue, prefetch queue, flush control
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        pipelined fetch request to instruction memory
//   imem_rsp_valid/data              in-order instruction response
//   redirect_valid, redirect_pc      taken branch/jump target (low two bits ignored)
//   exc                              exception from execute
//   irq, irq_ack                     level interrupt request, one-cycle acknowledge
//   epc                              return PC for the flush being taken this cycle
//   out_valid/ready/instr/pc/pcp4    instruction handoff to decode
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter logic [XLEN-1:0] IRQ_VEC  = XLEN'(IRQ_VEC_DEFAULT),
   parameter logic [XLEN-1:0] EXC_VEC  = XLEN'(EXC_VEC_DEFAULT)
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            exc,
   input  logic            irq,
   output logic            irq_ack,
   output logic [XLEN-1:0] epc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pcp4
);

   localparam int          CW    = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   drop;
   flush_cause_e    cause;
   logic            flush;
   logic [XLEN-1:0] flush_pc;
   logic [CW:0]     pending;
   logic            req_fire;
   logic            rsp_drop;
   logic            fill;
   logic            pop;
   logic            head_filled;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_instr;
   logic            q_empty;
   logic [CW-1:0]   occupancy;
   logic [CW-1:0]   in_flight;

   // Highest-priority cause wins; interrupts are only taken in user mode
   // (fetch_pc MSB clear). Nothing is taken while reset is asserted.
   always_comb begin
      cause    = CAUSE_NONE;
      flush_pc = fetch_pc;
      if (!reset) begin
         cause = CAUSE_NONE;
      end else if (exc) begin
         cause    = CAUSE_EXC;
         flush_pc = EXC_VEC;
      end else if (redirect_valid) begin
         cause    = CAUSE_REDIR;
         flush_pc = {redirect_pc[XLEN-1:2], 2'b00};
      end else if (irq && !fetch_pc[XLEN-1]) begin
         cause    = CAUSE_IRQ;
         flush_pc = IRQ_VEC;
      end
   end

   assign flush   = (cause != CAUSE_NONE);
   assign irq_ack = (cause == CAUSE_IRQ);
   assign epc     = q_empty ? fetch_pc : head_pc;

   // Every outstanding memory transaction holds a credit until its response
   // returns, whether it will be kept (queue slot) or discarded (drop).
   assign pending        = {1'b0, occupancy} + {1'b0, in_flight} + {1'b0, drop};
   assign imem_req_valid = reset && !flush && (pending < LIMIT);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_drop = imem_rsp_valid && (drop != '0);
   assign fill     = imem_rsp_valid && (drop == '0) && !flush;

   // The flush hides the head so decode can never consume an instruction in
   // the same cycle it is being squashed; epc then names that head.
   assign out_valid = head_filled && !flush;
   assign pop       = out_valid && out_ready;
   assign out_instr = head_instr;
   assign out_pc    = head_pc;
   assign out_pcp4  = head_pc + XLEN'(4);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         drop     <= '0;
      end else if (flush) begin
         fetch_pc <= flush_pc;
         // Everything still outstanding becomes stale, except a response
         // arriving right now, which is discarded along with the queue.
         drop     <= drop + in_flight - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (rsp_drop) begin
            drop <= drop - CW'(1);
         end
      end
   end

   fetch_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .alloc       (req_fire),
      .alloc_pc    (fetch_pc),
      .fill        (fill),
      .fill_data   (imem_rsp_data),
      .pop         (pop),
      .head_filled (head_filled),
      .head_pc     (head_pc),
      .head_instr  (head_instr),
      .empty       (q_empty),
      .occupancy   (occupancy),
      .in_flight   (in_flight)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Ports: none (top-level bench); drives fetch_unit with a 1-cycle in-order memory model.
module tb_fetch_unit;

   localparam logic [31:0] K = 32'h1357_9BDF;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        exc;
   logic        irq;
   logic        irq_ack;
   logic [31:0] epc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pcp4;

   int          checks = 0;
   int          errors = 0;
   logic        hold;
   logic [31:0] pend [$];
   logic [31:0] iss  [$];
   logic [31:0] dpc  [$];
   logic [31:0] dins [$];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .exc            (exc),
      .irq            (irq),
      .irq_ack        (irq_ack),
      .epc            (epc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pcp4       (out_pcp4)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock: record handshakes before the edge, then present the
   // response for any request accepted on an earlier edge (in order).
   task automatic cycle();
      logic        hs;
      logic [31:0] a;
      #1;
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      if (hs) begin
         pend.push_back(a);
         iss.push_back(a);
      end
      if (out_valid && out_ready) begin
         dpc.push_back(out_pc);
         dins.push_back(out_instr);
      end
      @(posedge clk);
      #1;
      if (!hold && pend.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pend.pop_front() ^ K;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      exc            = 1'b0;
      irq            = 1'b0;
      hold           = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      pend.delete();
      iss.delete();
      dpc.delete();
      dins.delete();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   initial begin
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      exc            = 1'b0;
      irq            = 1'b1;
      out_ready      = 1'b1;
      hold           = 1'b0;
      #3;
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_irq_ack", 32'(irq_ack), 32'h0);
      check("rst_epc", epc, 32'h0000_0000);

      // Streaming with zero-wait memory.
      do_reset();
      run(10);
      check("t1_iss_count", iss.size(), 32'd10);
      for (int i = 0; i < 10 && i < iss.size(); i++) check("t1_iss_addr", iss[i], 32'(i * 4));
      check("t1_dlv_count", dpc.size(), 32'd8);
      for (int i = 0; i < 8 && i < dpc.size(); i++) check("t1_dlv_pc", dpc[i], 32'(i * 4));
      check("t1_instr0", dins[0], 32'h1357_9BDF);

      // Decode stalled: exactly DEPTH requests, then resume at 0x10.
      do_reset();
      out_ready = 1'b0;
      run(8);
      check("t2_iss_count", iss.size(), 32'd4);
      check("t2_iss_last", iss[3], 32'h0000_000C);
      #1;
      check("t2_full_req", 32'(imem_req_valid), 32'h0);
      check("t2_head_valid", 32'(out_valid), 32'h1);
      check("t2_head_pc", out_pc, 32'h0);
      out_ready = 1'b1;
      #1;
      check("t2_pop_no_issue", 32'(imem_req_valid), 32'h0);
      cycle();
      #1;
      check("t2_resume_req", 32'(imem_req_valid), 32'h1);
      check("t2_resume_addr", imem_req_addr, 32'h0000_0010);

      // Redirect with three requests in flight.
      do_reset();
      hold = 1'b1;
      run(3);
      check("t3_inflight", iss.size(), 32'd3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0123;
      hold           = 1'b0;
      #1;
      check("t3_flush_req", 32'(imem_req_valid), 32'h0);
      check("t3_flush_out", 32'(out_valid), 32'h0);
      cycle();
      redirect_valid = 1'b0;
      #1;
      check("t3_tgt_req", 32'(imem_req_valid), 32'h1);
      check("t3_tgt_addr", imem_req_addr, 32'h0000_0120);
      run(9);
      check("t3_iss3", iss[3], 32'h0000_0120);
      check("t3_iss4", iss[4], 32'h0000_0124);
      check("t3_dlv_count", dpc.size(), 32'd5);
      check("t3_first_pc", dpc[0], 32'h0000_0120);
      check("t3_first_instr", dins[0], 32'h1357_9AFF);
      check("t3_second_pc", dpc[1], 32'h0000_0124);

      // Exception and redirect together: exception wins.
      do_reset();
      out_ready = 1'b0;
      run(6);
      exc            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      #1;
      check("t4_epc", epc, 32'h0000_0000);
      check("t4_flush_out", 32'(out_valid), 32'h0);
      check("t4_flush_req", 32'(imem_req_valid), 32'h0);
      check("t4_no_ack", 32'(irq_ack), 32'h0);
      cycle();
      exc            = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check("t4_vec_req", 32'(imem_req_valid), 32'h1);
      check("t4_vec_addr", imem_req_addr, 32'h8000_0008);
      cycle();
      #1;
      check("t4_n2_out", 32'(out_valid), 32'h0);
      out_ready = 1'b1;
      cycle();
      #1;
      check("t4_n3_out", 32'(out_valid), 32'h1);
      check("t4_n3_pc", out_pc, 32'h8000_0008);

      // Interrupts: redirect beats irq, irq taken next cycle, ignored in kernel.
      do_reset();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      irq            = 1'b1;
      #1;
      check("t5_redir_beats_irq", 32'(irq_ack), 32'h0);
      cycle();
      redirect_valid = 1'b0;
      #1;
      check("t5_ack", 32'(irq_ack), 32'h1);
      check("t5_epc", epc, 32'h0000_0040);
      check("t5_flush_req", 32'(imem_req_valid), 32'h0);
      cycle();
      imem_req_ready = 1'b1;
      #1;
      check("t5_ack_pulse", 32'(irq_ack), 32'h0);
      check("t5_vec_addr", imem_req_addr, 32'h8000_0004);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      cycle();
      redirect_valid = 1'b0;
      #1;
      check("t5_kernel_no_ack", 32'(irq_ack), 32'h0);
      check("t5_kernel_req", 32'(imem_req_valid), 32'h1);
      check("t5_kernel_addr", imem_req_addr, 32'h8000_0100);
      irq = 1'b0;

      // PC wrap and asynchronous reset mid-stream.
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      #1;
      check("t6_wrap_req0", imem_req_addr, 32'hFFFF_FFFC);
      cycle();
      #1;
      check("t6_wrap_req1", imem_req_addr, 32'h0000_0000);
      cycle();
      #1;
      check("t6_out_valid", 32'(out_valid), 32'h1);
      check("t6_out_pc", out_pc, 32'hFFFF_FFFC);
      check("t6_out_pcp4", out_pcp4, 32'h0000_0000);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_req", 32'(imem_req_valid), 32'h0);
      check("t6_rst_out", 32'(out_valid), 32'h0);
      check("t6_rst_ack", 32'(irq_ack), 32'h0);
      check("t6_rst_epc", epc, 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
